// File: rtl/mem_arbiter_nch_if.sv
// Requester channels plus the 8-bit serial RAM/IO bus of the N-channel memory arbiter.
// The slave modport is the arbiter; the master modport is the requester/memory side.
interface mem_arbiter_nch_if #(
   parameter int NCH    = 3,
   parameter int ADDR_W = 32
);
   logic                   rdy;
   logic                   io_buffer_full;
   logic                   flush;
   logic [7:0]             mem_din;
   logic [7:0]             mem_dout;
   logic [ADDR_W-1:0]      mem_a;
   logic                   mem_wr;
   logic [NCH-1:0]         req_valid;
   logic [NCH-1:0]         req_write;
   logic [2*NCH-1:0]       req_size;
   logic [NCH-1:0]         req_signed;
   logic [NCH-1:0]         req_cancel;
   logic [ADDR_W*NCH-1:0]  req_addr;
   logic [32*NCH-1:0]      req_wdata;
   logic [NCH-1:0]         resp_done;
   logic [31:0]            resp_data;
   logic                   busy;

   modport slave (
      input  rdy, io_buffer_full, flush, mem_din,
      input  req_valid, req_write, req_size, req_signed, req_cancel, req_addr, req_wdata,
      output mem_dout, mem_a, mem_wr, resp_done, resp_data, busy
   );

   modport master (
      output rdy, io_buffer_full, flush, mem_din,
      output req_valid, req_write, req_size, req_signed, req_cancel, req_addr, req_wdata,
      input  mem_dout, mem_a, mem_wr, resp_done, resp_data, busy
   );
endinterface

// File: rtl/mem_arbiter_nch.sv
// NCH-channel arbiter serialising 1/2/4-byte accesses onto an 8-bit bus; store done at n+1, load done at n+2.
// rdy low freezes everything; IO stores wait while the UART buffer is full; flush kills cancelable transfers.
module mem_arbiter_nch #(
   parameter int NCH    = 3,
   parameter int ADDR_W = 32,
   parameter int RR     = 1
) (
   input  logic             clk,
   input  logic             rst,
   mem_arbiter_nch_if.slave bus
);
   localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

   typedef enum logic [1:0] {IDLE, XFER, IO_WAIT} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     ptr_q, ptr_d, ch_q, ch_d;
   logic              wr_q, wr_d, sgn_q, sgn_d, cancel_q, cancel_d;
   logic [2:0]        n_q, n_d, k_q, k_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d, ld_q, ld_d;
   logic [ADDR_W-1:0] mem_a_q, mem_a_d;
   logic [7:0]        dout_q, dout_d;
   logic              mem_wr_q, mem_wr_d;
   logic [NCH-1:0]    done_q, done_d, pdone_q;
   logic [31:0]       rdata_q, rdata_d;

   logic [NCH-1:0]    elig;
   logic [CW-1:0]     cand, win;
   logic              win_vld;
   logic [2:0]        nxt;
   logic [1:0]        lb, sb;
   logic [ADDR_W-1:0] g_addr;
   logic [31:0]       g_wdata;
   logic              g_wr;

   function automatic logic [2:0] nbytes(input logic [1:0] s);
      case (s)
         2'd0:    nbytes = 3'd1;
         2'd1:    nbytes = 3'd2;
         default: nbytes = 3'd4;
      endcase
   endfunction

   function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] n, input logic s);
      case (n)
         3'd1:    extend = {{24{s & v[7]}}, v[7:0]};
         3'd2:    extend = {{16{s & v[15]}}, v[15:0]};
         default: extend = v;
      endcase
   endfunction

   // A channel finishing this cycle or last cycle still shows req_valid; skip it.
   assign elig = bus.req_valid & ~done_q & ~pdone_q & ~(bus.req_cancel & {NCH{bus.flush}});

   always_comb begin
      win_vld = 1'b0;
      win     = '0;
      cand    = '0;
      for (int i = 1; i <= NCH; i++) begin
         if (RR != 0) cand = CW'((int'(ptr_q) + i) % NCH);
         else         cand = CW'(i - 1);
         if (!win_vld && elig[cand]) begin
            win_vld = 1'b1;
            win     = cand;
         end
      end
   end

   assign g_addr  = bus.req_addr[win*ADDR_W +: ADDR_W];
   assign g_wdata = bus.req_wdata[win*32 +: 32];
   assign g_wr    = bus.req_write[win];

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      ch_d     = ch_q;
      wr_d     = wr_q;
      sgn_d    = sgn_q;
      cancel_d = cancel_q;
      n_d      = n_q;
      k_d      = k_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      ld_d     = ld_q;
      mem_a_d  = '0;
      dout_d   = dout_q;
      mem_wr_d = 1'b0;
      done_d   = '0;
      rdata_d  = rdata_q;
      nxt      = k_q + 3'd1;
      lb       = 2'(k_q - 3'd1);
      sb       = nxt[1:0];
      case (state_q)
         IDLE: begin
            if (win_vld) begin
               ch_d     = win;
               if (RR != 0) ptr_d = win;
               wr_d     = g_wr;
               sgn_d    = bus.req_signed[win];
               cancel_d = bus.req_cancel[win];
               n_d      = nbytes(bus.req_size[win*2 +: 2]);
               k_d      = 3'd0;
               addr_d   = g_addr;
               wdata_d  = g_wdata;
               ld_d     = '0;
               if (g_wr && g_addr[17:16] == 2'b11 && bus.io_buffer_full) begin
                  state_d = IO_WAIT;
               end else begin
                  state_d  = XFER;
                  mem_a_d  = g_addr;
                  mem_wr_d = g_wr;
                  dout_d   = g_wdata[7:0];
               end
            end
         end
         IO_WAIT: begin
            if (!bus.io_buffer_full) begin
               state_d  = XFER;
               mem_a_d  = addr_q;
               mem_wr_d = 1'b1;
               dout_d   = wdata_q[7:0];
            end
         end
         XFER: begin
            if (bus.flush && cancel_q) begin
               state_d = IDLE;
            end else if (wr_q) begin
               if (nxt < n_q) begin
                  k_d      = nxt;
                  mem_a_d  = addr_q + ADDR_W'(nxt);
                  mem_wr_d = 1'b1;
                  dout_d   = wdata_q[{sb, 3'b000} +: 8];
               end else begin
                  done_d[ch_q] = 1'b1;
                  state_d      = IDLE;
               end
            end else begin
               // Load bytes return one cycle behind their address.
               if (k_q != 3'd0) ld_d[{lb, 3'b000} +: 8] = bus.mem_din;
               if (nxt < n_q) mem_a_d = addr_q + ADDR_W'(nxt);
               k_d = nxt;
               if (k_q == n_q) begin
                  done_d[ch_q] = 1'b1;
                  rdata_d      = extend(ld_d, n_q, sgn_q);
                  state_d      = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         ptr_q    <= CW'(NCH - 1);
         ch_q     <= '0;
         wr_q     <= 1'b0;
         sgn_q    <= 1'b0;
         cancel_q <= 1'b0;
         n_q      <= 3'd0;
         k_q      <= 3'd0;
         addr_q   <= '0;
         wdata_q  <= '0;
         ld_q     <= '0;
         mem_a_q  <= '0;
         dout_q   <= '0;
         mem_wr_q <= 1'b0;
         done_q   <= '0;
         pdone_q  <= '0;
         rdata_q  <= '0;
      end else if (bus.rdy) begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         ch_q     <= ch_d;
         wr_q     <= wr_d;
         sgn_q    <= sgn_d;
         cancel_q <= cancel_d;
         n_q      <= n_d;
         k_q      <= k_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         ld_q     <= ld_d;
         mem_a_q  <= mem_a_d;
         dout_q   <= dout_d;
         mem_wr_q <= mem_wr_d;
         done_q   <= done_d;
         pdone_q  <= done_q;
         rdata_q  <= rdata_d;
      end
   end

   assign bus.mem_a     = mem_a_q;
   assign bus.mem_dout  = dout_q;
   assign bus.mem_wr    = mem_wr_q & bus.rdy;
   assign bus.resp_done = done_q;
   assign bus.resp_data = rdata_q;
   assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arbiter_nch.sv
// Scoreboard bench: round-robin DUT fully checked, fixed-priority twin checked for grant order.
module tb_mem_arbiter_nch;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   bit   fp_en = 1'b0;
   logic [7:0] ram [0:4095];

   typedef struct { int cyc; logic [2:0] ch; logic [31:0] data; bit chk; } resp_t;
   typedef struct { int cyc; bit wr; logic [31:0] a; logic [7:0] dout; } bus_t;
   resp_t resp_q[$];
   resp_t fp_q[$];
   bus_t  bus_q[$];
   resp_t r;
   bus_t  b;

   mem_arbiter_nch_if #(.NCH(3), .ADDR_W(32)) mif();
   mem_arbiter_nch_if #(.NCH(3), .ADDR_W(32)) fif();

   mem_arbiter_nch #(.NCH(3), .ADDR_W(32), .RR(1)) dut    (.clk(clk), .rst(rst), .bus(mif));
   mem_arbiter_nch #(.NCH(3), .ADDR_W(32), .RR(0)) dut_fp (.clk(clk), .rst(rst), .bus(fif));

   assign fif.rdy            = mif.rdy;
   assign fif.io_buffer_full = mif.io_buffer_full;
   assign fif.flush          = mif.flush;
   assign fif.mem_din        = mif.mem_din;
   assign fif.req_valid      = mif.req_valid;
   assign fif.req_write      = mif.req_write;
   assign fif.req_size       = mif.req_size;
   assign fif.req_signed     = mif.req_signed;
   assign fif.req_cancel     = mif.req_cancel;
   assign fif.req_addr       = mif.req_addr;
   assign fif.req_wdata      = mif.req_wdata;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) mif.mem_din <= ram[mif.mem_a[11:0]];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   task automatic bad(input string nm);
      checks++;
      failures++;
      $display("FAIL %s at cycle %0d", nm, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_resp(input int c, input logic [2:0] ch, input logic [31:0] d, input bit k);
      resp_t e;
      e.cyc = c; e.ch = ch; e.data = d; e.chk = k;
      resp_q.push_back(e);
   endtask

   task automatic push_fp(input int c, input logic [2:0] ch);
      resp_t e;
      e.cyc = c; e.ch = ch; e.data = '0; e.chk = 1'b0;
      fp_q.push_back(e);
   endtask

   task automatic push_bus(input int c, input bit w, input logic [31:0] a, input logic [7:0] d);
      bus_t e;
      e.cyc = c; e.wr = w; e.a = a; e.dout = d;
      bus_q.push_back(e);
   endtask

   task automatic set_req(input int ch, input bit wr, input logic [1:0] sz, input bit sg,
                          input bit cn, input logic [31:0] a, input logic [31:0] wd);
      mif.req_write[ch]          = wr;
      mif.req_size[2*ch +: 2]    = sz;
      mif.req_signed[ch]         = sg;
      mif.req_cancel[ch]         = cn;
      mif.req_addr[32*ch +: 32]  = a;
      mif.req_wdata[32*ch +: 32] = wd;
      mif.req_valid[ch]          = 1'b1;
   endtask

   task automatic wait_done(input int ch);
      bit seen = 1'b0;
      for (int t = 0; t < 40; t++) begin
         tick();
         if (mif.resp_done[ch]) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) bad("done_timeout");
      tick();
      mif.req_valid[ch] = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (mif.resp_done != 3'b000) begin
            if (resp_q.size() == 0) bad("resp_unexpected");
            else begin
               r = resp_q.pop_front();
               chk("resp_cycle", 64'(cyc), 64'(r.cyc));
               chk("resp_channel", 64'(mif.resp_done), 64'(r.ch));
               if (r.chk) chk("resp_data", 64'(mif.resp_data), 64'(r.data));
            end
         end
         if (mif.mem_wr || mif.mem_a != 32'h0) begin
            if (bus_q.size() == 0) bad("bus_unexpected");
            else begin
               b = bus_q.pop_front();
               chk("bus_cycle", 64'(cyc), 64'(b.cyc));
               chk("bus_wr", 64'(mif.mem_wr), 64'(b.wr));
               chk("bus_addr", 64'(mif.mem_a), 64'(b.a));
               if (b.wr) chk("bus_dout", 64'(mif.mem_dout), 64'(b.dout));
            end
         end
         if (fp_en && fif.resp_done != 3'b000) begin
            if (fp_q.size() == 0) bad("fp_resp_unexpected");
            else begin
               r = fp_q.pop_front();
               chk("fp_cycle", 64'(cyc), 64'(r.cyc));
               chk("fp_channel", 64'(fif.resp_done), 64'(r.ch));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int g;
      for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
      ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h84;
      ram[12'h300] = 8'h80;
      ram[12'h310] = 8'h34; ram[12'h311] = 8'h92;
      ram[12'h400] = 8'hA0; ram[12'h401] = 8'hA1; ram[12'h402] = 8'hA2;
      mif.rdy = 1'b1; mif.io_buffer_full = 1'b0; mif.flush = 1'b0;
      mif.req_valid = '0; mif.req_write = '0; mif.req_size = '0; mif.req_signed = '0;
      mif.req_cancel = '0; mif.req_addr = '0; mif.req_wdata = '0;
      rst = 1'b1;
      repeat (3) tick();
      chk("rst_mem_a", 64'(mif.mem_a), 64'h0);
      chk("rst_mem_dout", 64'(mif.mem_dout), 64'h0);
      chk("rst_mem_wr", 64'(mif.mem_wr), 64'h0);
      chk("rst_resp_done", 64'(mif.resp_done), 64'h0);
      chk("rst_resp_data", 64'(mif.resp_data), 64'h0);
      chk("rst_busy", 64'(mif.busy), 64'h0);
      rst = 1'b0;
      repeat (2) tick();

      // Signed word load on ch1.
      g = cyc;
      set_req(1, 1'b0, 2'd2, 1'b1, 1'b0, 32'h100, 32'h0);
      for (int k = 0; k < 4; k++) push_bus(g + 1 + k, 1'b0, 32'h100 + k, 8'h00);
      push_resp(g + 6, 3'b010, 32'h84332211, 1'b1);
      wait_done(1);
      repeat (2) tick();

      // Byte load 0x80, signed then unsigned; then signed half load.
      g = cyc;
      set_req(0, 1'b0, 2'd0, 1'b1, 1'b0, 32'h300, 32'h0);
      push_bus(g + 1, 1'b0, 32'h300, 8'h00);
      push_resp(g + 3, 3'b001, 32'hFFFFFF80, 1'b1);
      wait_done(0);
      repeat (2) tick();
      g = cyc;
      set_req(0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h300, 32'h0);
      push_bus(g + 1, 1'b0, 32'h300, 8'h00);
      push_resp(g + 3, 3'b001, 32'h00000080, 1'b1);
      wait_done(0);
      repeat (2) tick();
      g = cyc;
      set_req(0, 1'b0, 2'd1, 1'b1, 1'b0, 32'h310, 32'h0);
      push_bus(g + 1, 1'b0, 32'h310, 8'h00);
      push_bus(g + 2, 1'b0, 32'h311, 8'h00);
      push_resp(g + 4, 3'b001, 32'hFFFF9234, 1'b1);
      wait_done(0);
      repeat (2) tick();

      // Half store on ch2 crossing 0x1FF -> 0x200.
      g = cyc;
      set_req(2, 1'b1, 2'd1, 1'b0, 1'b0, 32'h1FF, 32'hDEADBEEF);
      push_bus(g + 1, 1'b1, 32'h1FF, 8'hEF);
      push_bus(g + 2, 1'b1, 32'h200, 8'hBE);
      push_resp(g + 3, 3'b100, 32'h0, 1'b0);
      wait_done(2);
      repeat (3) tick();

      // All three channels hold byte loads: RR 0,1,2,0 vs fixed 0,1,0,1.
      g = cyc;
      fp_en = 1'b1;
      set_req(0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h400, 32'h0);
      set_req(1, 1'b0, 2'd0, 1'b0, 1'b0, 32'h401, 32'h0);
      set_req(2, 1'b0, 2'd0, 1'b0, 1'b0, 32'h402, 32'h0);
      push_bus(g + 1, 1'b0, 32'h400, 8'h00);
      push_bus(g + 4, 1'b0, 32'h401, 8'h00);
      push_bus(g + 7, 1'b0, 32'h402, 8'h00);
      push_bus(g + 10, 1'b0, 32'h400, 8'h00);
      push_resp(g + 3, 3'b001, 32'hA0, 1'b1);
      push_resp(g + 6, 3'b010, 32'hA1, 1'b1);
      push_resp(g + 9, 3'b100, 32'hA2, 1'b1);
      push_resp(g + 12, 3'b001, 32'hA0, 1'b1);
      push_fp(g + 3, 3'b001);
      push_fp(g + 6, 3'b010);
      push_fp(g + 9, 3'b001);
      push_fp(g + 12, 3'b010);
      repeat (12) tick();
      mif.req_valid = '0;
      repeat (4) tick();
      fp_en = 1'b0;

      // Cancelable word load on ch1 flushed in cycle 2; ch2 store then wins.
      g = cyc;
      set_req(1, 1'b0, 2'd2, 1'b0, 1'b1, 32'h500, 32'h0);
      push_bus(g + 1, 1'b0, 32'h500, 8'h00);
      push_bus(g + 2, 1'b0, 32'h501, 8'h00);
      push_bus(g + 4, 1'b1, 32'h600, 8'h34);
      push_bus(g + 5, 1'b1, 32'h601, 8'h12);
      push_resp(g + 6, 3'b100, 32'h0, 1'b0);
      tick();
      set_req(2, 1'b1, 2'd1, 1'b0, 1'b0, 32'h600, 32'h00001234);
      tick();
      mif.flush = 1'b1;
      tick();
      mif.flush = 1'b0;
      mif.req_valid[1] = 1'b0;
      chk("flush_busy", 64'(mif.busy), 64'h0);
      chk("flush_mem_wr", 64'(mif.mem_wr), 64'h0);
      wait_done(2);
      repeat (2) tick();

      // IO store held off by a full buffer, then stalled by rdy mid-word.
      g = cyc;
      mif.io_buffer_full = 1'b1;
      set_req(0, 1'b1, 2'd2, 1'b0, 1'b0, 32'h30000, 32'hA1B2C3D4);
      push_bus(g + 6, 1'b1, 32'h30000, 8'hD4);
      push_bus(g + 7, 1'b1, 32'h30001, 8'hC3);
      push_bus(g + 8, 1'b0, 32'h30002, 8'h00);
      push_bus(g + 9, 1'b0, 32'h30002, 8'h00);
      push_bus(g + 10, 1'b1, 32'h30002, 8'hB2);
      push_bus(g + 11, 1'b1, 32'h30003, 8'hA1);
      push_resp(g + 12, 3'b001, 32'h0, 1'b0);
      repeat (5) tick();
      mif.io_buffer_full = 1'b0;
      repeat (3) tick();
      mif.rdy = 1'b0;
      repeat (2) tick();
      mif.rdy = 1'b1;
      wait_done(0);
      repeat (4) tick();

      chk("resp_queue_left", 64'(resp_q.size()), 64'h0);
      chk("bus_queue_left", 64'(bus_q.size()), 64'h0);
      chk("fp_queue_left", 64'(fp_q.size()), 64'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
